apb_sw_event_gen: RTL and testbench

- Software-to-hardware event source: the counterpart of the event-to-level-interrupt receiver.
- The core writes event IDs over APB. They are buffered in a small FIFO and emitted on a valid/ready event handshake towards the FC event/interrupt fabric.
- Used to inject software events (test, IPC, wake-up) into the same event path that peripherals drive.

---
 rtl/apb_sw_event_gen_pkg.sv | 37 +++
 rtl/apb_sw_event_gen_if.sv | 24 ++
 rtl/apb_sw_event_gen_fifo.sv | 77 +++++++
 rtl/apb_sw_event_gen.sv | 96 +++++++++
 tb/tb_apb_sw_event_gen.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/apb_sw_event_gen_pkg.sv
// Register map and bit positions shared by the software event generator.
package apb_sw_event_gen_pkg;

    // Register offsets within the 256-byte APB window
    localparam logic [7:0] REG_PUSH   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_CTRL   = 8'h08;

    // STATUS field positions (fill count occupies the low bits)
    localparam int unsigned STATUS_EMPTY_BIT = 16;
    localparam int unsigned STATUS_FULL_BIT  = 17;
    localparam int unsigned STATUS_OVF_BIT   = 18;

    // CTRL field positions
    localparam int unsigned CTRL_CLR_OVF_BIT = 0;
    localparam int unsigned CTRL_FLUSH_BIT   = 1;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_PUSH,
        SEL_STATUS,
        SEL_CTRL
    } reg_sel_e;

    // Map the decoded address byte onto a register select
    function automatic reg_sel_e decode_reg(input logic [7:0] addr);
        reg_sel_e sel;
        case (addr)
            REG_PUSH:   sel = SEL_PUSH;
            REG_STATUS: sel = SEL_STATUS;
            REG_CTRL:   sel = SEL_CTRL;
            default:    sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/apb_sw_event_gen_if.sv
// APB register bus carried between the core and the event generator.
// Handshake: an access is performed in the cycle where psel && penable;
// pready is constantly 1, so every access completes in that one cycle and
// prdata/pslverr are valid only during it.
interface apb_sw_event_gen_if;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_sw_event_gen_fifo.sv
// Small synchronous FIFO with a fifo_v3 style port list. A push into a full
// FIFO is accepted when a pop happens in the same cycle, so the caller
// decides when a push is legal. flush_i empties the FIFO and overrides any
// push/pop of the same cycle.
module apb_sw_event_gen_fifo #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CNT_WIDTH-1:0]  usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0]     rptr_q;
    logic [ADDR_W-1:0]     wptr_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  bypass;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    assign full_o  = (cnt_q == CNT_WIDTH'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;

    // In fall-through mode a push and pop into an empty FIFO pass straight through
    assign bypass  = FALL_THROUGH && empty_o && push_i && pop_i;
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok) && !bypass;

    assign data_o = (FALL_THROUGH && empty_o) ? data_i : mem_q[rptr_q];

    // Pointer, counter and storage update; pointers wrap since DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/apb_sw_event_gen.sv
// Software event source: the core pushes event IDs over APB, they are
// buffered and emitted on a valid/ready handshake into the event fabric.
// Event handshake: a transfer happens on event_valid_o && event_ready_i;
// while valid is high and ready low, data and valid hold (flush excepted).
module apb_sw_event_gen
    import apb_sw_event_gen_pkg::*;
#(
    parameter int unsigned EVENT_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned CNT_WIDTH   = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    apb_sw_event_gen_if.slave      ctrl,
    output logic [EVENT_WIDTH-1:0] event_data_o,
    output logic                   event_valid_o,
    input  logic                   event_ready_i,
    output logic                   overflow_o
);

    reg_sel_e             sel;
    logic                 access;
    logic                 push_req;
    logic                 ctrl_wr;
    logic                 flush;
    logic                 clr_ovf;
    logic                 pop;
    logic                 drop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_WIDTH-1:0] fifo_usage;
    logic                 overflow_q;
    logic                 unused_bits;

    assign unused_bits = ^{ctrl.paddr[31:8], ctrl.pwdata[31:EVENT_WIDTH]};

    assign sel      = decode_reg(ctrl.paddr[7:0]);
    assign access   = ctrl.psel && ctrl.penable;
    assign push_req = access && ctrl.pwrite && (sel == SEL_PUSH);
    assign ctrl_wr  = access && ctrl.pwrite && (sel == SEL_CTRL);
    assign flush    = ctrl_wr && ctrl.pwdata[CTRL_FLUSH_BIT];
    assign clr_ovf  = ctrl_wr && ctrl.pwdata[CTRL_CLR_OVF_BIT];

    // A flush discards the head, so a pop in the same cycle does not count
    assign pop  = event_valid_o && event_ready_i && !flush;
    // Full without a simultaneous pop: the event is lost and the access errors
    assign drop = push_req && fifo_full && !pop;

    apb_sw_event_gen_fifo #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (EVENT_WIDTH),
        .DEPTH        (FIFO_DEPTH),
        .CNT_WIDTH    (CNT_WIDTH)
    ) i_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush),
        .testmode_i (1'b0),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .usage_o    (fifo_usage),
        .data_i     (ctrl.pwdata[EVENT_WIDTH-1:0]),
        .push_i     (push_req && !drop),
        .data_o     (event_data_o),
        .pop_i      (pop)
    );

    assign event_valid_o = !fifo_empty;
    assign overflow_o    = overflow_q;

    // Sticky overflow; a set wins over a clear in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (clr_ovf) begin
            overflow_q <= 1'b0;
        end
    end

    // Read mux: only STATUS returns data, sampled before this cycle's updates
    always_comb begin
        ctrl.prdata = '0;
        if (!ctrl.pwrite && (sel == SEL_STATUS)) begin
            ctrl.prdata[CNT_WIDTH-1:0]    = fifo_usage;
            ctrl.prdata[STATUS_EMPTY_BIT] = fifo_empty;
            ctrl.prdata[STATUS_FULL_BIT]  = fifo_full;
            ctrl.prdata[STATUS_OVF_BIT]   = overflow_q;
        end
    end

    assign ctrl.pready  = 1'b1;
    assign ctrl.pslverr = drop;

endmodule

// File: tb/tb_apb_sw_event_gen.sv
// Directed bench for apb_sw_event_gen: APB pushes, drains through the
// event handshake, overflow, full-with-pop, flush and asynchronous reset.
module tb_apb_sw_event_gen;
    import apb_sw_event_gen_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] event_data_o;
    logic       event_valid_o;
    logic       event_ready_i = 1'b0;
    logic       overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    apb_sw_event_gen_if apb ();

    apb_sw_event_gen #(
        .EVENT_WIDTH (8),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .ctrl          (apb),
        .event_data_o  (event_data_o),
        .event_valid_o (event_valid_o),
        .event_ready_i (event_ready_i),
        .overflow_o    (overflow_o)
    );

    // Clock and idle bus
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One APB transfer; optionally raise event_ready_i during the access phase only
    task automatic apb_access(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                              input bit pop_in_access, output logic [31:0] rdata, output logic err);
        @(posedge clk_i); #1;
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = wr;
        apb.paddr   = {24'h0, addr};
        apb.pwdata  = data;
        @(posedge clk_i); #1;
        apb.penable   = 1'b1;
        event_ready_i = pop_in_access;
        @(negedge clk_i);
        rdata = apb.prdata;
        err   = apb.pslverr;
        @(posedge clk_i); #1;
        apb.psel      = 1'b0;
        apb.penable   = 1'b0;
        apb.pwrite    = 1'b0;
        event_ready_i = 1'b0;
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data, output logic err);
        logic [31:0] rd;
        apb_access(1'b1, addr, data, 1'b0, rd, err);
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] rdata);
        logic err;
        apb_access(1'b0, addr, 32'h0, 1'b0, rdata, err);
    endtask

    // Push an event that must be accepted and record it in the scoreboard
    task automatic push_evt(input logic [7:0] ev);
        logic err;
        apb_write(REG_PUSH, {24'h0, ev}, err);
        check_eq("push_pslverr", {31'h0, err}, 32'h0);
        exp_q.push_back(ev);
    endtask

    // Hold ready high for n transfers and compare each head against the scoreboard
    task automatic drain(input int n);
        logic [7:0] exp_ev;
        event_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            exp_ev = exp_q.pop_front();
            check_eq("drain_valid", {31'h0, event_valid_o}, 32'h1);
            check_eq("drain_data", {24'h0, event_data_o}, {24'h0, exp_ev});
        end
        @(negedge clk_i);
        check_eq("drain_empty_valid", {31'h0, event_valid_o}, 32'h0);
        @(posedge clk_i); #1;
        event_ready_i = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;

        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = '0;
        apb.pwdata  = '0;

        // Reset
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        check_eq("rst_valid", {31'h0, event_valid_o}, 32'h0);
        check_eq("rst_data", {24'h0, event_data_o}, 32'h0);
        check_eq("rst_overflow", {31'h0, overflow_o}, 32'h0);
        check_eq("rst_pready", {31'h0, apb.pready}, 32'h1);
        apb_read(REG_STATUS, rd);
        check_eq("rst_status", rd, 32'h0001_0000);

        // Unmapped and write-only registers read as zero; unmapped writes are ignored
        apb_read(REG_PUSH, rd);
        check_eq("push_reads_zero", rd, 32'h0);
        apb_read(REG_CTRL, rd);
        check_eq("ctrl_reads_zero", rd, 32'h0);
        apb_read(8'h0C, rd);
        check_eq("unmapped_read", rd, 32'h0);
        apb_write(8'h40, 32'h12, err);
        check_eq("unmapped_pslverr", {31'h0, err}, 32'h0);
        apb_read(REG_STATUS, rd);
        check_eq("unmapped_status", rd, 32'h0001_0000);

        // Three events, consumer stalled: head holds for 10 cycles
        push_evt(8'h11);
        check_eq("latency_valid", {31'h0, event_valid_o}, 32'h1);
        push_evt(8'h22);
        push_evt(8'h33);
        apb_read(REG_STATUS, rd);
        check_eq("status_cnt3", rd, 32'h0000_0003);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check_eq("hold_valid", {31'h0, event_valid_o}, 32'h1);
            check_eq("hold_data", {24'h0, event_data_o}, 32'h11);
        end
        @(posedge clk_i); #1;
        drain(3);

        // Overflow: fifth push into a depth-4 FIFO is dropped
        push_evt(8'hA0);
        push_evt(8'hA1);
        push_evt(8'hA2);
        push_evt(8'hA3);
        apb_write(REG_PUSH, 32'hA4, err);
        check_eq("ovf_pslverr", {31'h0, err}, 32'h1);
        check_eq("ovf_flag", {31'h0, overflow_o}, 32'h1);
        apb_read(REG_STATUS, rd);
        check_eq("ovf_status", rd, 32'h0006_0004);
        drain(4);
        check_eq("ovf_sticky", {31'h0, overflow_o}, 32'h1);
        apb_write(REG_CTRL, 32'h1, err);
        check_eq("clr_pslverr", {31'h0, err}, 32'h0);
        check_eq("ovf_cleared", {31'h0, overflow_o}, 32'h0);

        // Full FIFO, push coincides with a pop: accepted, count unchanged
        push_evt(8'hB0);
        push_evt(8'hB1);
        push_evt(8'hB2);
        push_evt(8'hB3);
        apb_access(1'b1, REG_PUSH, 32'h55, 1'b1, rd, err);
        check_eq("fullpop_pslverr", {31'h0, err}, 32'h0);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h55);
        check_eq("fullpop_overflow", {31'h0, overflow_o}, 32'h0);
        apb_read(REG_STATUS, rd);
        check_eq("fullpop_status", rd, 32'h0002_0004);
        drain(4);

        // Flush plus clear-overflow together, with a pop offered in the same cycle
        push_evt(8'hC0);
        push_evt(8'hC1);
        push_evt(8'hC2);
        push_evt(8'hC3);
        apb_write(REG_PUSH, 32'hC4, err);
        check_eq("flush_pre_pslverr", {31'h0, err}, 32'h1);
        check_eq("flush_pre_ovf", {31'h0, overflow_o}, 32'h1);
        apb_access(1'b1, REG_CTRL, 32'h3, 1'b1, rd, err);
        exp_q.delete();
        check_eq("flush_valid", {31'h0, event_valid_o}, 32'h0);
        check_eq("flush_ovf", {31'h0, overflow_o}, 32'h0);
        apb_read(REG_STATUS, rd);
        check_eq("flush_status", rd, 32'h0001_0000);
        push_evt(8'h7E);
        check_eq("post_flush_data", {24'h0, event_data_o}, 32'h7E);
        drain(1);

        // Asynchronous reset mid-drain with two entries left
        push_evt(8'hD0);
        push_evt(8'hD1);
        push_evt(8'hD2);
        event_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("rstmid_head", {24'h0, event_data_o}, 32'hD0);
        @(posedge clk_i); #1;
        event_ready_i = 1'b0;
        check_eq("rstmid_next", {24'h0, event_data_o}, 32'hD1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("rstmid_valid", {31'h0, event_valid_o}, 32'h0);
        check_eq("rstmid_ovf", {31'h0, overflow_o}, 32'h0);
        exp_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        apb_read(REG_STATUS, rd);
        check_eq("rstmid_status", rd, 32'h0001_0000);
        check_eq("rstmid_valid_after", {31'h0, event_valid_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
